// File: rtl/reduct_rr_sequencer.sv
// Round-robin sequencer sharing one external WIDTH-bit reduction register among NUM_REQ requesters.
// Optional macro REDUCT_SAT_EN: ACCUMULATE saturates to all ones on carry-out instead of wrapping.
module reduct_rr_sequencer #(
  parameter int unsigned            NUM_REQ    = 4,
  parameter int unsigned            WIDTH      = 16,
  parameter logic [WIDTH-1:0]       INIT_VALUE = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ-1:0]         req_op_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       busy_o,
  output logic                       ovf_o,
  input  logic [WIDTH-1:0]           reg_q_i,
  output logic [WIDTH-1:0]           reg_d_o,
  output logic [WIDTH-1:0]           reg_reset_value_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic             ovf_q, ovf_d;

  logic             win_found_s;
  logic [PTR_W-1:0] win_idx_s;
  logic [PTR_W-1:0] sel_idx_s;
  logic             sel_act_s;
  logic             commit_s;
  logic [WIDTH-1:0] data_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] acc_s;
  logic             carry_s;
  logic [PTR_W-1:0] next_ptr_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
    int unsigned nxt;
    nxt = int'(idx) + 1;
    if (nxt >= NUM_REQ) begin
      nxt = 0;
    end else begin
      nxt = nxt;
    end
    wrap_inc = PTR_W'(nxt);
  endfunction

  // IDLE arbitration: first valid requester scanning from rr_ptr with wrap.
  always_comb begin
    int unsigned pos;
    win_found_s = 1'b0;
    win_idx_s   = {PTR_W{1'b0}};
    pos         = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      pos = int'(rr_ptr_q) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end else begin
        pos = pos;
      end
      if (!win_found_s && req_valid_i[pos]) begin
        win_found_s = 1'b1;
        win_idx_s   = PTR_W'(pos);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Beat selection, datapath and outputs towards the register and requesters.
  always_comb begin
    if (state_q == ST_BURST) begin
      sel_idx_s = owner_q;
      sel_act_s = req_valid_i[owner_q];
    end else begin
      sel_idx_s = win_idx_s;
      sel_act_s = win_found_s;
    end
    commit_s   = sel_act_s && !rst && !clear_i;
    next_ptr_s = wrap_inc(sel_idx_s);
    data_s     = req_data_i[sel_idx_s*WIDTH +: WIDTH];
    sum_s      = {1'b0, reg_q_i} + {1'b0, data_s};
    carry_s    = sum_s[WIDTH];
`ifdef REDUCT_SAT_EN
    acc_s = carry_s ? {WIDTH{1'b1}} : sum_s[WIDTH-1:0];
`else
    acc_s = sum_s[WIDTH-1:0];
`endif

    if (rst || clear_i) begin
      reg_d_o = INIT_VALUE;
    end else if (commit_s) begin
      reg_d_o = req_op_i[sel_idx_s] ? acc_s : data_s;
    end else begin
      reg_d_o = reg_q_i;
    end

    if (commit_s) begin
      req_ready_o = onehot(sel_idx_s);
    end else begin
      req_ready_o = {NUM_REQ{1'b0}};
    end

    if (rst) begin
      grant_o = {NUM_REQ{1'b0}};
    end else if (state_q == ST_BURST) begin
      grant_o = onehot(owner_q);
    end else if (win_found_s) begin
      grant_o = onehot(win_idx_s);
    end else begin
      grant_o = {NUM_REQ{1'b0}};
    end
  end

  // Next-state: clear aborts bursts but keeps the pointer; last beat rotates it.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    ovf_d    = ovf_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      ovf_d   = 1'b0;
    end else if (commit_s) begin
      if (req_op_i[sel_idx_s] && carry_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      owner_d = sel_idx_s;
      if (req_last_i[sel_idx_s]) begin
        state_d  = ST_IDLE;
        rr_ptr_d = next_ptr_s;
      end else begin
        state_d = ST_BURST;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= {PTR_W{1'b0}};
      owner_q  <= {PTR_W{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o            = (state_q == ST_BURST) && !rst;
  assign ovf_o             = ovf_q;
  assign reg_reset_value_o = INIT_VALUE;

endmodule

// File: tb/tb_reduct_rr_sequencer.sv
// Self-checking bench for reduct_rr_sequencer with an external register model and a q scoreboard.
// Expectations follow the REDUCT_SAT_EN setting of the build.
module tb_reduct_rr_sequencer;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [3:0]  valid, op, last;
  logic [63:0] data;
  logic [3:0]  ready, grant;
  logic        busy, ovf;
  logic [15:0] reg_q, reg_d, reg_rv;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_v;
  logic [15:0] model_q;

  always #5 clk = ~clk;

  // External reduction register: loads d every edge.
  always_ff @(posedge clk) reg_q <= reg_d;

  reduct_rr_sequencer #(.NUM_REQ(4), .WIDTH(16), .INIT_VALUE(16'h0000)) dut (
    .clk(clk), .rst(rst), .clear_i(clear),
    .req_valid_i(valid), .req_op_i(op), .req_last_i(last), .req_data_i(data),
    .req_ready_o(ready), .grant_o(grant), .busy_o(busy), .ovf_o(ovf),
    .reg_q_i(reg_q), .reg_d_o(reg_d), .reg_reset_value_o(reg_rv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; valid = 4'hF; op = 4'h0; last = 4'hF; data = 64'h0004_0003_0002_0001;
    @(negedge clk);
    n_cmp++; if (ready !== 4'h0) begin n_err++; $display("FAIL rst_ready got %h exp 0", ready); end
    n_cmp++; if (grant !== 4'h0) begin n_err++; $display("FAIL rst_grant got %h exp 0", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (reg_d !== 16'h0000) begin n_err++; $display("FAIL rst_d got %h exp 0000", reg_d); end
    tick(); tick();
    rst = 1'b0; valid = 4'h0;
    @(negedge clk);
    n_cmp++; if (reg_q !== 16'h0000) begin n_err++; $display("FAIL rst_q got %h exp 0000", reg_q); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    n_cmp++; if (reg_rv !== 16'h0000) begin n_err++; $display("FAIL rst_value got %h exp 0000", reg_rv); end
    tick();
  endtask

  task automatic test_rr_load();
    logic [3:0] exp_g;
    int idx;
    valid = 4'hF; op = 4'h0; last = 4'hF;
    for (int i = 0; i < 4; i++) data[i*16 +: 16] = 16'(i + 1);
    for (int c = 0; c < 5; c++) begin
      idx = c % 4;
      exp_g = 4'b0001 << idx;
      @(negedge clk);
      n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL rr_grant c=%0d got %h exp %h", c, grant, exp_g); end
      n_cmp++; if (ready !== exp_g) begin n_err++; $display("FAIL rr_ready c=%0d got %h exp %h", c, ready, exp_g); end
      sb.push_back(16'(idx + 1));
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL rr_q c=%0d got %h exp %h", c, reg_q, exp_v); end
    end
    valid = 4'h0;
  endtask

  task automatic test_burst();
    clear = 1'b1; valid = 4'h0;
    @(negedge clk);
    n_cmp++; if (reg_d !== 16'h0000) begin n_err++; $display("FAIL burst_clr_d got %h exp 0000", reg_d); end
    tick();
    clear = 1'b0;
    model_q = 16'h0000;
    n_cmp++; if (reg_q !== model_q) begin n_err++; $display("FAIL burst_clr_q got %h exp %h", reg_q, model_q); end
    valid = 4'b0011; op = 4'b0010;
    data[15:0] = 16'h0007; data[31:16] = 16'h0005;
    for (int b = 0; b < 3; b++) begin
      last = (b == 2) ? 4'b0011 : 4'b0001;
      @(negedge clk);
      n_cmp++; if (ready !== 4'b0010) begin n_err++; $display("FAIL burst_ready b=%0d got %h exp 2", b, ready); end
      n_cmp++; if (busy !== (b != 0)) begin n_err++; $display("FAIL burst_busy b=%0d got %b", b, busy); end
      model_q = model_q + 16'h0005;
      sb.push_back(model_q);
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL burst_q b=%0d got %h exp %h", b, reg_q, exp_v); end
    end
    valid = 4'b0001; last = 4'b0001;
    @(negedge clk);
    n_cmp++; if (ready !== 4'b0001) begin n_err++; $display("FAIL wrap_ready got %h exp 1", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrap_busy got %b exp 0", busy); end
    sb.push_back(16'h0007);
    tick();
    exp_v = sb.pop_front();
    n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL wrap_q got %h exp %h", reg_q, exp_v); end
  endtask

  task automatic test_ovf();
    logic [15:0] exp1, exp2;
`ifdef REDUCT_SAT_EN
    exp1 = 16'hFFFF; exp2 = 16'hFFFF;
`else
    exp1 = 16'h0010; exp2 = 16'h0011;
`endif
    valid = 4'b0001; op = 4'b0000; last = 4'b0001; data[15:0] = 16'hFFF0;
    @(negedge clk);
    sb.push_back(16'hFFF0);
    tick();
    exp_v = sb.pop_front();
    n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL ovf_load got %h exp %h", reg_q, exp_v); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_pre got %b exp 0", ovf); end
    op = 4'b0001; data[15:0] = 16'h0020;
    @(negedge clk);
    sb.push_back(exp1);
    tick();
    exp_v = sb.pop_front();
    n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL ovf_acc got %h exp %h", reg_q, exp_v); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", ovf); end
    data[15:0] = 16'h0001;
    @(negedge clk);
    sb.push_back(exp2);
    tick();
    exp_v = sb.pop_front();
    n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL ovf_acc2 got %h exp %h", reg_q, exp_v); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
  endtask

  task automatic test_clear_mid_burst();
    valid = 4'b0100; op = 4'b0000; last = 4'b0000; data[47:32] = 16'h0003;
    @(negedge clk);
    n_cmp++; if (ready !== 4'b0100) begin n_err++; $display("FAIL clr_start_ready got %h exp 4", ready); end
    sb.push_back(16'h0003);
    tick();
    exp_v = sb.pop_front();
    n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL clr_start_q got %h exp %h", reg_q, exp_v); end
    clear = 1'b1;
    @(negedge clk);
    n_cmp++; if (ready !== 4'b0000) begin n_err++; $display("FAIL clr_ready got %h exp 0", ready); end
    n_cmp++; if (reg_d !== 16'h0000) begin n_err++; $display("FAIL clr_d got %h exp 0000", reg_d); end
    tick();
    clear = 1'b0;
    n_cmp++; if (reg_q !== 16'h0000) begin n_err++; $display("FAIL clr_q got %h exp 0000", reg_q); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b exp 0", ovf); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy got %b exp 0", busy); end
    last = 4'b0100; data[47:32] = 16'h0009;
    @(negedge clk);
    n_cmp++; if (ready !== 4'b0100) begin n_err++; $display("FAIL clr_after_ready got %h exp 4", ready); end
    sb.push_back(16'h0009);
    tick();
    exp_v = sb.pop_front();
    n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL clr_after_q got %h exp %h", reg_q, exp_v); end
  endtask

  task automatic test_rst_mid_burst();
    valid = 4'b1000; op = 4'b0000; last = 4'b0000; data[63:48] = 16'h0004;
    @(negedge clk);
    n_cmp++; if (ready !== 4'b1000) begin n_err++; $display("FAIL rstb_ready got %h exp 8", ready); end
    sb.push_back(16'h0004);
    tick();
    exp_v = sb.pop_front();
    n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL rstb_q got %h exp %h", reg_q, exp_v); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstb_busy got %b exp 1", busy); end
    rst = 1'b1; valid = 4'b1001; last = 4'b1001; data[15:0] = 16'h000A; data[63:48] = 16'h000B;
    @(negedge clk);
    n_cmp++; if ({ready, grant, busy} !== 9'h000) begin n_err++; $display("FAIL rstb_hold got r=%h g=%h b=%b exp 0", ready, grant, busy); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL rstb_after_grant got %h exp 1", grant); end
    sb.push_back(16'h000A);
    tick();
    exp_v = sb.pop_front();
    n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL rstb_after_q got %h exp %h", reg_q, exp_v); end
  endtask

  task automatic test_stall();
    valid = 4'b1010; op = 4'b0010; last = 4'b0000; data[31:16] = 16'h0002; data[63:48] = 16'h0001;
    @(negedge clk);
    n_cmp++; if (ready !== 4'b0010) begin n_err++; $display("FAIL stall_start_ready got %h exp 2", ready); end
    sb.push_back(16'h000C);
    tick();
    exp_v = sb.pop_front();
    n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL stall_start_q got %h exp %h", reg_q, exp_v); end
    valid = 4'b1000;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      n_cmp++; if (ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready s=%0d got %h exp 0", s, ready); end
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL stall_grant s=%0d got %h exp 2", s, grant); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy s=%0d got %b exp 1", s, busy); end
      tick();
      n_cmp++; if (reg_q !== 16'h000C) begin n_err++; $display("FAIL stall_q s=%0d got %h exp 000c", s, reg_q); end
    end
    valid = 4'b1010; last = 4'b0010;
    @(negedge clk);
    n_cmp++; if (ready !== 4'b0010) begin n_err++; $display("FAIL stall_end_ready got %h exp 2", ready); end
    sb.push_back(16'h000E);
    tick();
    exp_v = sb.pop_front();
    n_cmp++; if (reg_q !== exp_v) begin n_err++; $display("FAIL stall_end_q got %h exp %h", reg_q, exp_v); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_end_busy got %b exp 0", busy); end
    valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_rr_load();
    test_burst();
    test_ovf();
    test_clear_mid_burst();
    test_rst_mid_burst();
    test_stall();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_empty got %0d exp 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
